// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use scoreboard, cache stall and branch flush arbitration.
// Optional perf counters are built when HAZARD_PERF_EN is defined.
package hazard_pkg;
  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef struct packed {
    logic pc;
    logic if_id;
    logic id_ex;
    logic ex_mem;
    logic mem_wb;
  } stage_ctrl_t;

  typedef struct packed {
    stage_ctrl_t load;
    stage_ctrl_t rst;
  } pipeline_reg_ctrl_t;
endpackage

module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int LOAD_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  rv32i_opcode        ex_opcode,
  input  rv32i_opcode        id_opcode,
  input  logic [4:0]         ex_rd,
  input  logic [4:0]         id_sr1,
  input  logic [4:0]         id_sr2,
  input  logic               branch_rst,
  input  logic               imem_stall,
  input  logic               dmem_stall,
  output pipeline_reg_ctrl_t out,
  output logic               load_use_stall
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]        perf_stall_cycles,
  output logic [31:0]        perf_flushes,
  output logic [31:0]        perf_load_use
`endif
);

  // One dummy slot at LOAD_LAT==1 keeps the vectors legal; it is tied off below.
  localparam int SB_D = (LOAD_LAT > 1) ? LOAD_LAT - 1 : 1;

  logic [SB_D-1:0]       sb_vld;
  logic [SB_D-1:0][4:0]  sb_rd;
  logic                  ex_load, push;
  logic                  use1, use2, hit1, hit2, hazard;
  logic                  pending_flush, flush_set, flush_clr;

  assign ex_load = (ex_opcode == op_load);
  assign push    = ex_load && (ex_rd != 5'd0) && !branch_rst;

  generate
    if (LOAD_LAT > 1) begin : g_sb
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          sb_vld <= '0;
          sb_rd  <= '0;
        end else if (!dmem_stall) begin
          sb_vld[0] <= push;
          sb_rd[0]  <= push ? ex_rd : 5'd0;
          for (int i = 1; i < SB_D; i++) begin
            sb_vld[i] <= sb_vld[i-1];
            sb_rd[i]  <= sb_rd[i-1];
          end
        end
      end
    end else begin : g_nosb
      assign sb_vld = '0;
      assign sb_rd  = '0;
    end
  endgenerate

  always_comb begin
    use1 = !(id_opcode inside {op_lui, op_auipc, op_jal});
    use2 = id_opcode inside {op_reg, op_br, op_store};
    hit1 = ex_load && (ex_rd == id_sr1);
    hit2 = ex_load && (ex_rd == id_sr2);
    for (int i = 0; i < SB_D; i++) begin
      hit1 = hit1 || (sb_vld[i] && (sb_rd[i] == id_sr1));
      hit2 = hit2 || (sb_vld[i] && (sb_rd[i] == id_sr2));
    end
    hazard = (use1 && (id_sr1 != 5'd0) && hit1) ||
             (use2 && (id_sr2 != 5'd0) && hit2);
  end

  always_comb begin
    out            = '0;
    out.load       = '1;
    load_use_stall = 1'b0;
    flush_set      = 1'b0;
    flush_clr      = 1'b0;
    if (dmem_stall) begin
      out.load = '0;
    end else if (branch_rst) begin
      out.rst.if_id  = 1'b1;
      out.rst.id_ex  = 1'b1;
      out.rst.ex_mem = 1'b1;
      flush_set      = imem_stall;
    end else if (pending_flush && !imem_stall) begin
      // A hazard takes precedence: the bubble keeps the wrong-path fetch out of EX anyway.
      flush_clr = 1'b1;
      if (hazard) begin
        out.load.pc    = 1'b0;
        out.load.if_id = 1'b0;
        out.rst.id_ex  = 1'b1;
        load_use_stall = 1'b1;
      end else begin
        out.rst.if_id  = 1'b1;
      end
    end else if (imem_stall) begin
      out.load.pc    = 1'b0;
      out.load.if_id = 1'b0;
      out.rst.id_ex  = 1'b1;
    end else if (hazard) begin
      out.load.pc    = 1'b0;
      out.load.if_id = 1'b0;
      out.rst.id_ex  = 1'b1;
      load_use_stall = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           pending_flush <= 1'b0;
    else if (flush_set) pending_flush <= 1'b1;
    else if (flush_clr) pending_flush <= 1'b0;
  end

`ifdef HAZARD_PERF_EN
  // pc is held only by the stall rules; ex_mem is reset only by a branch flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_cycles <= '0;
      perf_flushes      <= '0;
      perf_load_use     <= '0;
    end else begin
      if (!out.load.pc && (perf_stall_cycles != '1))
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (out.rst.ex_mem && (perf_flushes != '1))
        perf_flushes <= perf_flushes + 32'd1;
      if (load_use_stall && (perf_load_use != '1))
        perf_load_use <= perf_load_use + 32'd1;
    end
  end
`endif

endmodule

// File: doc/hazard_ctrl_unit.md
# hazard_ctrl_unit

Parametrised pipeline hazard controller for the 5-stage RV32I core, generating per-stage load/reset controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. Extends single-bubble load-use detection to a configurable load-to-use latency using an in-flight load scoreboard. Also arbitrates instruction- and data-memory stalls and branch flushes, including a flush that must be deferred past an outstanding I-cache fetch. Sits in the CPU top between the stage registers and the cache response signals.

## Interface
- LOAD_LAT, 1: cycles a load result stays unforwardable after leaving EX; legal 1..4. Scoreboard depth is LOAD_LAT-1; at 1 there is no scoreboard.
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-low
- ex_opcode  in  rv32i_opcode  opcode in EX
- id_opcode  in  rv32i_opcode  opcode in ID
- ex_rd  in  5  destination register in EX
- id_sr1, id_sr2  in  5 each  ID source registers
- branch_rst  in  1  mispredict/redirect resolved this cycle
- imem_stall  in  1  I-cache response not ready
- dmem_stall  in  1  D-cache access in MEM not complete
- out  out  pipeline_reg_ctrl_t  .load and .rst, fields pc, if_id, id_ex, ex_mem, mem_wb
- load_use_stall  out  1  load-use bubble inserted this cycle
- perf_stall_cycles, perf_flushes, perf_load_use  out  32 each  (HAZARD_PERF_EN only)

## Operation
- Source usage:
  - sr1 is used by all opcodes except op_lui, op_auipc, op_jal.
  - sr2 is used only by op_reg, op_br, op_store.
- Hazard: ID uses srN != 0, and either (ex_opcode==op_load && ex_rd==srN) or some valid scoreboard entry has rd==srN.
- Scoreboard:
  - Entries {valid, rd[4:0]}, index 0..LOAD_LAT-2.
  - Push when ex_opcode==op_load, ex_rd!=0 and !branch_rst.
  - Every cycle without dmem_stall: entry[0] <= push ? {1,ex_rd} : {0,0}; entry[i] <= entry[i-1]; the oldest entry drops off.
  - On dmem_stall, all entries hold.
- Defaults: all .load=1, all .rst=0. Priority is highest first:
  1. dmem_stall: all .load=0, no .rst. branch_rst is ignored; upstream must re-assert it.
  2. branch_rst: .rst if_id, id_ex, ex_mem; pc loads the redirect. If imem_stall is also high, set pending_flush.
  3. pending_flush && !imem_stall: .rst if_id to discard the wrong-path response; clear pending_flush. If a hazard is also present, apply rule 5 instead of the if_id reset; pending_flush still clears.
  4. imem_stall: pc.load=0, if_id.load=0, id_ex.rst=1.
  5. hazard: pc.load=0, if_id.load=0, id_ex.rst=1, load_use_stall=1.
- load_use_stall is asserted only when rule 5 is the applied rule.
- pending_flush is set only by rule 2 and cleared only by rule 3 (or by reset).

## Timing
- Outputs are combinational from inputs plus registered state (scoreboard, pending_flush, counters). There is no output latency.
- State updates on the rising edge of clk.
- rst low, asynchronous, mid-operation: scoreboard invalid, pending_flush=0, counters=0.
- Outputs during reset follow the priority rules with that cleared state.
- A load in EX blocks ID for exactly LOAD_LAT consecutive unstalled cycles. dmem_stall cycles extend the block without consuming it.
- branch_rst together with a load in EX: no push, and the load's hazard is not reported because rule 2 outranks it.

## Configuration
- HAZARD_PERF_EN defined: three 32-bit saturating counters (stop at 0xFFFFFFFF).
  - perf_stall_cycles: +1 per cycle with rule 1, 4 or 5 applied.
  - perf_flushes: +1 per applied rule 2.
  - perf_load_use: +1 per applied rule 5.
- HAZARD_PERF_EN undefined: the counters and ports are absent; behaviour is otherwise identical.

## Test plan
- LOAD_LAT=1, EX lw x5, ID add x6,x5,x0 -> one cycle with pc/if_id.load=0, id_ex.rst=1, load_use_stall=1; the next cycle is clear.
- LOAD_LAT=3, lw x7 then add x8,x7,x7 in ID -> exactly 3 bubble cycles. With dmem_stall held 2 cycles mid-sequence, still 3 bubbles plus 2 frozen cycles (all .load=0).
- lw x0 followed by a use of x0; lui x5 after lw x5; addi x9,x5,1 after lw x6 using sr2 field=6 -> no stall in any case.
- branch_rst with imem_stall=1 for 3 cycles -> flush cycle resets if_id/id_ex/ex_mem; then 2 cycles of rule 4; on the first imem_stall=0 cycle if_id.rst=1 and pending clears.
- branch_rst and dmem_stall together -> all .load=0, no .rst, pending_flush stays 0.
- HAZARD_PERF_EN: preload counters near saturation via 0xFFFFFFFE stall cycles -> counter holds at 0xFFFFFFFF. rst pulse low mid-count -> counters and scoreboard clear immediately.
